// File: rtl/wavegen_pkg.sv
// Shared definitions for the wave generator ramp source: mode encodings,
// direction constants and saturating sign helpers on a wide working type.
package wavegen_pkg;

   // Working width for internal arithmetic. It is wide enough that sums and
   // differences of two samples never overflow for N_FRAC up to 13.
   localparam int WIDE = 16;
   typedef logic signed [WIDE-1:0] wide_t;
   localparam wide_t ONE = wide_t'(1);

   typedef enum logic [1:0] {
      MODE_WRAP     = 2'd0,
      MODE_FOLD     = 2'd1,
      MODE_TRIANGLE = 2'd2,
      MODE_ONESHOT  = 2'd3
   } mode_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Negate a Q0.nf value; the most negative code maps to the most positive.
   function automatic wide_t sat_neg(input wide_t x, input int nf);
      wide_t lim;
      lim = ONE << nf;
      return (x == -lim) ? (lim - ONE) : -x;
   endfunction

   // Magnitude of a Q0.nf value with the same saturation as sat_neg.
   function automatic wide_t sat_abs(input wide_t x, input int nf);
      return (x < 0) ? sat_neg(x, nf) : x;
   endfunction

endpackage

// File: rtl/ramp_step.sv
// Combinational next-state for the ramp: new sample, direction, done flag
// and the cycle-event flag, for whichever mode is selected.
module ramp_step
   import wavegen_pkg::*;
#(
   parameter int N_FRAC = 7,
   localparam int W = N_FRAC + 1
) (
   input  logic signed [W-1:0] value,
   input  logic signed [W-1:0] amplitude,
   input  logic signed [W-1:0] addend,
   input  mode_t               mode,
   input  logic                dir,
   input  logic                done,
   output logic signed [W-1:0] value_next,
   output logic                dir_next,
   output logic                done_next,
   output logic                cycle
);

   localparam wide_t HI_LIM = (ONE << N_FRAC) - ONE;
   localparam wide_t LO_LIM = -(ONE << N_FRAC);

   wide_t v, a, d, mag, sum, s, vn;

   // Widen the operands; a negative amplitude behaves as zero.
   always_comb begin
      v   = wide_t'(value);
      d   = wide_t'(addend);
      a   = wide_t'(amplitude);
      if (a < 0) a = '0;
      mag = sat_abs(d, N_FRAC);
      sum = v + d;
   end

   // Per-mode step; a zero addend holds the sample in every mode.
   always_comb begin
      vn        = v;
      s         = v;
      dir_next  = dir;
      done_next = 1'b0;
      cycle     = 1'b0;
      if (d == 0) begin
         done_next = (mode == MODE_ONESHOT) ? done : 1'b0;
      end else begin
         case (mode)
            MODE_WRAP: begin
               vn    = sum;
               cycle = (sum > HI_LIM) || (sum < LO_LIM);
            end
            MODE_FOLD: begin
               if (v <= a) begin
                  vn = sum;
               end else begin
                  vn    = sat_neg(v, N_FRAC);
                  cycle = 1'b1;
               end
            end
            MODE_TRIANGLE: begin
               if (dir == DIR_UP) begin
                  s = v + mag;
                  if (s > a) begin
                     vn       = a;
                     dir_next = DIR_DOWN;
                     cycle    = 1'b1;
                  end else if (s < -a) begin
                     // entered below the band while heading up: pull to bound
                     vn = -a;
                  end else begin
                     vn = s;
                  end
               end else begin
                  s = v - mag;
                  if (s < -a) begin
                     vn       = -a;
                     dir_next = DIR_UP;
                     cycle    = 1'b1;
                  end else if (s > a) begin
                     vn = a;
                  end else begin
                     vn = s;
                  end
               end
            end
            default: begin // MODE_ONESHOT
               if (done) begin
                  done_next = 1'b1;
               end else if (sum > a) begin
                  vn        = a;
                  done_next = 1'b1;
                  cycle     = 1'b1;
               end else if (sum < -a) begin
                  vn        = -a;
                  done_next = 1'b1;
                  cycle     = 1'b1;
               end else begin
                  vn = sum;
               end
            end
         endcase
      end
   end

   // Truncation to W bits gives the two's-complement wrap.
   assign value_next = vn[W-1:0];

endmodule

// File: rtl/ramp_generator.sv
// Multi-mode ramp source: one signed sample per accepted request strobe,
// with cycle-event pulse, one-shot done level and synchronous clear.
module ramp_generator
   import wavegen_pkg::*;
#(
   parameter int N_FRAC = 7,
   localparam int W = N_FRAC + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic signed [W-1:0] amplitude_i,
   input  logic signed [W-1:0] addend_i,
   input  logic [1:0]          mode_i,
   input  logic                enable_i,
   input  logic                clear_i,
   input  logic                next_data_strobe_i,
   output logic signed [W-1:0] data_o,
   output logic                data_out_valid_strobe_o,
   output logic                cycle_o,
   output logic                done_o
);

   logic signed [W-1:0] value_q, value_nx;
   logic                dir_q, dir_nx;
   logic                done_q, done_nx;
   logic                valid_q, cycle_q, cycle_nx;
   logic                accept;

   assign accept = next_data_strobe_i & enable_i & ~clear_i;

   ramp_step #(.N_FRAC(N_FRAC)) u_step (
      .value      (value_q),
      .amplitude  (amplitude_i),
      .addend     (addend_i),
      .mode       (mode_t'(mode_i)),
      .dir        (dir_q),
      .done       (done_q),
      .value_next (value_nx),
      .dir_next   (dir_nx),
      .done_next  (done_nx),
      .cycle      (cycle_nx)
   );

   // State registers; clear beats a coincident strobe, reset beats everything.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         value_q <= '0;
         dir_q   <= DIR_UP;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         cycle_q <= 1'b0;
      end else begin
         valid_q <= accept;
         cycle_q <= accept & cycle_nx;
         if (clear_i) begin
            value_q <= '0;
            dir_q   <= DIR_UP;
            done_q  <= 1'b0;
         end else if (accept) begin
            value_q <= value_nx;
            dir_q   <= dir_nx;
            done_q  <= done_nx;
         end
      end
   end

   assign data_o                  = value_q;
   assign data_out_valid_strobe_o = valid_q;
   assign cycle_o                 = cycle_q;
   assign done_o                  = done_q;

endmodule

// File: tb/tb_ramp_generator.sv
// Directed self-checking bench for ramp_generator (N_FRAC=7, 8-bit samples).
module tb_ramp_generator;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic signed [7:0] amplitude = '0;
   logic signed [7:0] addend = '0;
   logic [1:0]        mode = '0;
   logic              enable = 1'b0;
   logic              clear = 1'b0;
   logic              strobe = 1'b0;
   logic signed [7:0] data;
   logic              valid, cycle, done;

   int n_cmp = 0;
   int n_err = 0;

   ramp_generator #(.N_FRAC(7)) dut (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .amplitude_i             (amplitude),
      .addend_i                (addend),
      .mode_i                  (mode),
      .enable_i                (enable),
      .clear_i                 (clear),
      .next_data_strobe_i      (strobe),
      .data_o                  (data),
      .data_out_valid_strobe_o (valid),
      .cycle_o                 (cycle),
      .done_o                  (done)
   );

   always #5 clk = ~clk;

   // One request strobe; returns at the falling edge after the accepting edge.
   task automatic pulse(input logic en, input logic clr);
      @(negedge clk);
      strobe = 1'b1; enable = en; clear = clr;
      @(negedge clk);
      strobe = 1'b0; enable = 1'b1; clear = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset(input string tag);
      @(negedge clk);
      rst = 1'b0; strobe = 1'b1; enable = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (data !== 8'sd0 || valid !== 1'b0 || done !== 1'b0 || cycle !== 1'b0) begin
         n_err++;
         $display("FAIL %s: data=%0d valid=%b done=%b cycle=%b, want 0 0 0 0", tag, data, valid, done, cycle);
      end
      rst = 1'b1; strobe = 1'b0;
   endtask

   task automatic test_wrap();
      int exp_d[8] = '{16, 32, 48, 64, 80, 96, 112, -128};
      mode = 2'd0; addend = 8'sd16; amplitude = 8'sd127;
      for (int i = 0; i < 8; i++) begin
         pulse(1'b1, 1'b0);
         n_cmp++;
         if (int'(data) !== exp_d[i] || valid !== 1'b1 || cycle !== (i == 7)) begin
            n_err++;
            $display("FAIL wrap[%0d]: data=%0d valid=%b cycle=%b, want %0d 1 %b", i, data, valid, cycle, exp_d[i], i == 7);
         end
      end
      // a couple more samples so the next reset lands mid-ramp
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      n_cmp++;
      if (int'(data) !== -96) begin
         n_err++;
         $display("FAIL wrap_cont: data=%0d, want -96", data);
      end
   endtask

   task automatic test_fold();
      int exp_d[8] = '{32, 64, 96, -96, -64, -32, 0, 32};
      mode = 2'd1; amplitude = 8'sd64; addend = 8'sd32;
      for (int i = 0; i < 8; i++) begin
         pulse(1'b1, 1'b0);
         n_cmp++;
         if (int'(data) !== exp_d[i] || valid !== 1'b1 || cycle !== (i == 3)) begin
            n_err++;
            $display("FAIL fold[%0d]: data=%0d cycle=%b, want %0d %b", i, data, cycle, exp_d[i], i == 3);
         end
      end
   endtask

   task automatic test_triangle();
      // reaching exactly -A is still in range; reversal comes on the next step
      int exp_d[10]   = '{40, 80, 100, 60, 20, -20, -60, -100, -100, -60};
      logic exp_c[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
      do_clear();
      mode = 2'd2; amplitude = 8'sd100; addend = 8'sd40;
      for (int i = 0; i < 10; i++) begin
         pulse(1'b1, 1'b0);
         n_cmp++;
         if (int'(data) !== exp_d[i] || valid !== 1'b1 || cycle !== exp_c[i]) begin
            n_err++;
            $display("FAIL tri[%0d]: data=%0d cycle=%b, want %0d %b", i, data, cycle, exp_d[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_addend_sat();
      // |-128| saturates to 127: first step lands on 127 without reversing
      int exp_d[3]   = '{127, 127, 0};
      logic exp_c[3] = '{0, 1, 0};
      do_clear();
      mode = 2'd2; amplitude = 8'sd127; addend = -8'sd128;
      for (int i = 0; i < 3; i++) begin
         pulse(1'b1, 1'b0);
         n_cmp++;
         if (int'(data) !== exp_d[i] || cycle !== exp_c[i]) begin
            n_err++;
            $display("FAIL sat[%0d]: data=%0d cycle=%b, want %0d %b", i, data, cycle, exp_d[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_oneshot();
      int exp_d[5]   = '{-20, -40, -50, -50, -50};
      logic exp_c[5] = '{0, 0, 1, 0, 0};
      logic exp_n[5] = '{0, 0, 1, 1, 1};
      do_clear();
      mode = 2'd3; amplitude = 8'sd50; addend = -8'sd20;
      for (int i = 0; i < 5; i++) begin
         pulse(1'b1, 1'b0);
         n_cmp++;
         if (int'(data) !== exp_d[i] || valid !== 1'b1 || cycle !== exp_c[i] || done !== exp_n[i]) begin
            n_err++;
            $display("FAIL oneshot[%0d]: data=%0d valid=%b cycle=%b done=%b, want %0d 1 %b %b",
                     i, data, valid, cycle, done, exp_d[i], exp_c[i], exp_n[i]);
         end
      end
      do_clear();
      n_cmp++;
      if (data !== 8'sd0 || done !== 1'b0 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL oneshot_clear: data=%0d done=%b valid=%b, want 0 0 0", data, done, valid);
      end
   endtask

   task automatic test_gating();
      mode = 2'd0; addend = 8'sd16;
      pulse(1'b1, 1'b0);
      n_cmp++;
      if (int'(data) !== 16 || valid !== 1'b1) begin
         n_err++;
         $display("FAIL gate_base: data=%0d valid=%b, want 16 1", data, valid);
      end
      pulse(1'b0, 1'b0);
      n_cmp++;
      if (int'(data) !== 16 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL gate_disabled: data=%0d valid=%b, want 16 0", data, valid);
      end
      addend = 8'sd0;
      pulse(1'b1, 1'b0);
      n_cmp++;
      if (int'(data) !== 16 || valid !== 1'b1 || cycle !== 1'b0) begin
         n_err++;
         $display("FAIL zero_addend: data=%0d valid=%b cycle=%b, want 16 1 0", data, valid, cycle);
      end
      addend = 8'sd16;
      pulse(1'b1, 1'b1);
      n_cmp++;
      if (int'(data) !== 0 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL strobe_with_clear: data=%0d valid=%b, want 0 0", data, valid);
      end
   endtask

   initial begin
      test_reset("reset_initial");
      test_wrap();
      test_reset("reset_mid_ramp");
      test_fold();
      test_triangle();
      test_addend_sat();
      test_oneshot();
      test_gating();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
